// File: rtl/link_tx_sched.sv
// Link transmit scheduler: arbitrates response requests and streams each frame byte-wise to a UART.
// Latency: request pulse to first tx_start is 4 cycles; each byte waits for tx_busy low before launch.
module link_tx_sched #(
  parameter int UBUF_BYTES = 32,
  parameter int BUSY_TO    = 15
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        link_rx_wr_cmplt,
  input  logic        get_status,
  input  logic        get_current_nonce,
  input  logic        get_signature,
  input  logic        read_ubuf,
  input  logic        host_break,
  input  logic [7:0]  status_byte,
  input  logic [31:0] current_nonce,
  input  logic [31:0] signature,
  output logic        ubuf_rd,
  output logic [4:0]  ubuf_addr,
  input  logic [7:0]  ubuf_data,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        tx_active,
  output logic        frame_done,
  output logic        tx_err
);

  localparam int CW = $clog2(UBUF_BYTES + 1);
  localparam int TW = $clog2(BUSY_TO + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_FETCH   = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;
  localparam logic [2:0] S_WAIT_LO = 3'd6;

  localparam logic [2:0] T_ACK    = 3'd0;
  localparam logic [2:0] T_STATUS = 3'd1;
  localparam logic [2:0] T_NONCE  = 3'd2;
  localparam logic [2:0] T_SIG    = 3'd3;
  localparam logic [2:0] T_UBUF   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    ftype;
  logic [4:0]    pending;
  logic [4:0]    req;
  logic [4:0]    win_oh;
  logic [2:0]    win_type;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] frame_len;
  logic [TW-1:0] to_cnt;
  logic [7:0]    status_q;
  logic [31:0]   nonce_q;
  logic [31:0]   word;
  logic [1:0]    idx;
  logic [7:0]    load_byte;
  logic          brk;
  logic          last;
  logic          is_ubuf_pl;

  assign req = {read_ubuf, get_signature, get_current_nonce, get_status, link_rx_wr_cmplt};

  always_comb begin
    win_oh   = 5'b00000;
    win_type = T_ACK;
    if (pending[0]) begin
      win_oh = 5'b00001; win_type = T_ACK;
    end else if (pending[1]) begin
      win_oh = 5'b00010; win_type = T_STATUS;
    end else if (pending[2]) begin
      win_oh = 5'b00100; win_type = T_NONCE;
    end else if (pending[3]) begin
      win_oh = 5'b01000; win_type = T_SIG;
    end else if (pending[4]) begin
      win_oh = 5'b10000; win_type = T_UBUF;
    end
  end

  always_comb begin
    case (ftype)
      T_STATUS:      frame_len = CW'(1);
      T_NONCE, T_SIG: frame_len = CW'(4);
      T_UBUF:        frame_len = CW'(UBUF_BYTES);
      default:       frame_len = '0;
    endcase
  end

  assign last       = (byte_cnt == frame_len);
  assign is_ubuf_pl = (ftype == T_UBUF) && (byte_cnt != '0);
  assign idx        = 2'(byte_cnt - CW'(1));
  assign word       = (ftype == T_NONCE) ? nonce_q : signature;

  // Header byte at position 0; payload words go out least-significant byte first.
  always_comb begin
    load_byte = 8'h00;
    if (byte_cnt == '0) begin
      case (ftype)
        T_ACK:    load_byte = 8'h4B;
        T_STATUS: load_byte = 8'h53;
        T_NONCE:  load_byte = 8'h6E;
        T_SIG:    load_byte = 8'h49;
        T_UBUF:   load_byte = 8'h52;
        default:  load_byte = 8'h00;
      endcase
    end else if (ftype == T_STATUS) begin
      load_byte = status_q;
    end else begin
      case (idx)
        2'd0:    load_byte = word[7:0];
        2'd1:    load_byte = word[15:8];
        2'd2:    load_byte = word[23:16];
        default: load_byte = word[31:24];
      endcase
    end
  end

  assign tx_start  = (state == S_SEND) && !tx_busy && !host_break;
  assign ubuf_rd   = (state == S_LOAD) && is_ubuf_pl;
  assign ubuf_addr = ubuf_rd ? 5'(byte_cnt - CW'(1)) : 5'd0;
  assign tx_active = (state != S_IDLE);

  // A same-cycle request re-arms the bit being cleared, so repeats are served again later.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 5'b00000;
    end else if (host_break) begin
      pending <= 5'b00000;
    end else begin
      pending <= (pending & ~((state == S_GRANT) ? win_oh : 5'b00000)) | req;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ftype      <= T_ACK;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      status_q   <= 8'h00;
      nonce_q    <= 32'h0;
      tx_byte    <= 8'h00;
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
      brk        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (host_break) tx_err <= 1'b0;
      case (state)
        S_IDLE: begin
          brk <= 1'b0;
          if (|pending && !host_break) state <= S_GRANT;
        end
        S_GRANT: begin
          if (host_break) begin
            state <= S_IDLE;
          end else begin
            ftype    <= win_type;
            status_q <= status_byte;
            nonce_q  <= current_nonce;
            byte_cnt <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (host_break) begin
            state <= S_IDLE;
          end else if (is_ubuf_pl) begin
            state <= S_FETCH;
          end else begin
            tx_byte <= load_byte;
            state   <= S_SEND;
          end
        end
        S_FETCH: begin
          if (host_break) begin
            state <= S_IDLE;
          end else begin
            tx_byte <= ubuf_data;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (host_break) begin
            state <= S_IDLE;
          end else if (!tx_busy) begin
            to_cnt <= '0;
            state  <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (host_break) brk <= 1'b1;
          if (tx_busy) begin
            state <= S_WAIT_LO;
          end else if (to_cnt == TW'(BUSY_TO - 1)) begin
            tx_err <= ~host_break;
            state  <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_WAIT_LO: begin
          if (host_break) brk <= 1'b1;
          if (!tx_busy) begin
            if (brk || host_break) begin
              state <= S_IDLE;
            end else if (last) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              state    <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_tx_sched.sv
// Directed bench for link_tx_sched with a 10-cycle-busy UART model and an identity user-buffer RAM.
module tb_link_tx_sched;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic        link_rx_wr_cmplt, get_status, get_current_nonce, get_signature, read_ubuf, host_break;
  logic [7:0]  status_byte;
  logic [31:0] current_nonce, signature;
  logic        ubuf_rd;
  logic [4:0]  ubuf_addr;
  logic [7:0]  ubuf_data;
  logic [7:0]  tx_byte;
  logic        tx_start, tx_busy, tx_active, frame_done, tx_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          first_start = -1;
  int          fd_cnt = 0;
  int          busy_left = 0;
  int          c;
  bit          uart_stuck = 1'b0;
  logic [7:0]  tx_log[$];
  logic [4:0]  addr_log[$];
  logic [7:0]  exp_q[$];

  link_tx_sched dut (
    .clk_25(clk_25), .rst_n(rst_n),
    .link_rx_wr_cmplt(link_rx_wr_cmplt), .get_status(get_status),
    .get_current_nonce(get_current_nonce), .get_signature(get_signature),
    .read_ubuf(read_ubuf), .host_break(host_break),
    .status_byte(status_byte), .current_nonce(current_nonce), .signature(signature),
    .ubuf_rd(ubuf_rd), .ubuf_addr(ubuf_addr), .ubuf_data(ubuf_data),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_active(tx_active), .frame_done(frame_done), .tx_err(tx_err)
  );

  always #20 clk_25 = ~clk_25;

  // UART and RAM model: observe mid-cycle, respond just after the rising edge.
  initial begin : model
    logic       start_now, rd_now;
    logic [4:0] addr_now;
    tx_busy   = 1'b0;
    ubuf_data = 8'h00;
    forever begin
      @(negedge clk_25);
      start_now = tx_start;
      rd_now    = ubuf_rd;
      addr_now  = ubuf_addr;
      if (tx_start) begin
        tx_log.push_back(tx_byte);
        if (first_start < 0) first_start = cyc;
      end
      if (ubuf_rd) addr_log.push_back(ubuf_addr);
      if (frame_done) fd_cnt++;
      @(posedge clk_25);
      cyc++;
      #1;
      if (busy_left > 0) busy_left--;
      if (start_now && !uart_stuck) busy_left = 10;
      if (uart_stuck) busy_left = 0;
      tx_busy = (busy_left > 0);
      if (rd_now) ubuf_data = {3'b000, addr_now};
    end
  end

  initial begin : watchdog
    #(40 * 20000);
    $display("FAIL watchdog: time limit expired, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk(tag, log_at(i), exp_q[i]);
  endtask

  task automatic clear_log();
    tx_log.delete();
    addr_log.delete();
    first_start = -1;
    fd_cnt = 0;
  endtask

  task automatic pulse(input int sel);
    case (sel)
      0: link_rx_wr_cmplt  = 1'b1;
      1: get_status        = 1'b1;
      2: get_current_nonce = 1'b1;
      3: get_signature     = 1'b1;
      4: read_ubuf         = 1'b1;
      default: host_break  = 1'b1;
    endcase
    @(negedge clk_25);
    {link_rx_wr_cmplt, get_status, get_current_nonce, get_signature, read_ubuf, host_break} = '0;
  endtask

  task automatic wait_quiet(input int max);
    int q = 0;
    for (int i = 0; i < max && q < 3; i++) begin
      @(negedge clk_25);
      if (!tx_active && !tx_busy) q++;
      else q = 0;
    end
    chk("quiet", q, 3);
  endtask

  task automatic wait_log(input int n, input int max);
    for (int i = 0; i < max && tx_log.size() < n; i++) @(negedge clk_25);
    chk("log_reach", tx_log.size() >= n, 1);
  endtask

  initial begin : stim
    rst_n = 1'b0;
    {link_rx_wr_cmplt, get_status, get_current_nonce, get_signature, read_ubuf, host_break} = '0;
    status_byte = 8'h00; current_nonce = 32'h0; signature = 32'h0;
    repeat (3) @(negedge clk_25);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ubuf_rd", ubuf_rd, 0);
    chk("rst_ubuf_addr", ubuf_addr, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_tx_err", tx_err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_25);

    // Status frame, 4-cycle launch latency, payload snapshotted at grant
    clear_log(); status_byte = 8'hA5; c = cyc;
    pulse(1);
    chk("t1_still_idle", tx_active, 0);
    @(negedge clk_25); chk("t1_active", tx_active, 1);
    @(negedge clk_25); status_byte = 8'h00;
    @(negedge clk_25);
    chk("t1_start_now", tx_start, 1);
    chk("t1_hdr_byte", tx_byte, 8'h53);
    wait_quiet(200);
    chk("t1_first_start", first_start, c + 4);
    exp_q = '{8'h53, 8'hA5}; cmp_log("t1_bytes");
    chk("t1_frame_done", fd_cnt, 1);

    // Ack outranks signature; signature little-endian
    clear_log(); signature = 32'h11223344;
    get_signature = 1'b1; link_rx_wr_cmplt = 1'b1;
    @(negedge clk_25);
    get_signature = 1'b0; link_rx_wr_cmplt = 1'b0;
    wait_quiet(400);
    exp_q = '{8'h4B, 8'h49, 8'h44, 8'h33, 8'h22, 8'h11}; cmp_log("t2_bytes");
    chk("t2_frame_done", fd_cnt, 2);

    // Back-to-back nonce requests merge into one frame
    clear_log(); current_nonce = 32'hA1B2C3D4;
    get_current_nonce = 1'b1;
    repeat (2) @(negedge clk_25);
    get_current_nonce = 1'b0;
    repeat (2) @(negedge clk_25);
    current_nonce = 32'h0;
    wait_quiet(300);
    exp_q = '{8'h6E, 8'hD4, 8'hC3, 8'hB2, 8'hA1}; cmp_log("t3_bytes");
    chk("t3_frame_done", fd_cnt, 1);

    // Re-request of the type in flight is served again with a fresh snapshot
    clear_log(); status_byte = 8'h3C;
    pulse(1);
    wait_log(1, 50);
    pulse(1);
    status_byte = 8'h7E;
    wait_quiet(300);
    exp_q = '{8'h53, 8'h3C, 8'h53, 8'h7E}; cmp_log("t4_bytes");
    chk("t4_frame_done", fd_cnt, 2);

    // User-buffer dump
    clear_log();
    pulse(4);
    wait_quiet(1000);
    exp_q = '{8'h52};
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(i));
    cmp_log("t5_bytes");
    chk("t5_addr_len", addr_log.size(), 32);
    for (int i = 0; i < 32 && i < addr_log.size(); i++) chk("t5_addr", addr_log[i], i);
    chk("t5_frame_done", fd_cnt, 1);

    // Break while nonce byte 2 is on the wire, with status pending
    clear_log(); current_nonce = 32'hCAFEF00D;
    pulse(2);
    wait_log(1, 50);
    pulse(1);
    wait_log(3, 200);
    repeat (2) @(negedge clk_25);
    pulse(5);
    chk("t6_byte_finishing", tx_active, 1);
    wait_quiet(200);
    repeat (20) @(negedge clk_25);
    exp_q = '{8'h6E, 8'h0D, 8'hF0}; cmp_log("t6_bytes");
    chk("t6_no_frame_done", fd_cnt, 0);
    chk("t6_idle", tx_active, 0);

    // Break during GRANT: no launch
    clear_log();
    pulse(1);
    @(negedge clk_25);
    pulse(5);
    chk("t7_idle", tx_active, 0);
    repeat (30) @(negedge clk_25);
    chk("t7_no_bytes", tx_log.size(), 0);
    chk("t7_no_frame_done", fd_cnt, 0);

    // Break drops a request arriving in the same cycle
    clear_log();
    host_break = 1'b1; get_signature = 1'b1;
    @(negedge clk_25);
    host_break = 1'b0; get_signature = 1'b0;
    repeat (20) @(negedge clk_25);
    chk("t8_no_bytes", tx_log.size(), 0);
    chk("t8_idle", tx_active, 0);

    // Transmitter never goes busy: timeout 16 cycles after tx_start
    clear_log(); uart_stuck = 1'b1; c = cyc;
    pulse(0);
    repeat (18) @(negedge clk_25);
    chk("t9_err_not_yet", tx_err, 0);
    chk("t9_still_waiting", tx_active, 1);
    @(negedge clk_25);
    chk("t9_err_set", tx_err, 1);
    chk("t9_idle", tx_active, 0);
    chk("t9_first_start", first_start, c + 4);
    chk("t9_no_frame_done", fd_cnt, 0);
    uart_stuck = 1'b0;
    repeat (3) @(negedge clk_25);
    chk("t9_err_sticky", tx_err, 1);
    pulse(5);
    chk("t9_err_cleared", tx_err, 0);

    // Reset mid-frame aborts at once
    clear_log(); status_byte = 8'h99;
    pulse(1);
    wait_log(1, 50);
    repeat (3) @(negedge clk_25);
    rst_n = 1'b0;
    #1;
    chk("t10_rst_active", tx_active, 0);
    chk("t10_rst_start", tx_start, 0);
    chk("t10_rst_byte", tx_byte, 0);
    repeat (3) @(negedge clk_25);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_25);
    chk("t10_one_byte", tx_log.size(), 1);
    chk("t10_no_frame_done", fd_cnt, 0);
    chk("t10_idle", tx_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/link_tx_sched.md
LINK_TX_SCHED -- requirements
Module: link_tx_sched

Interface
REQ-001 Parameter UBUF_BYTES, default 32: number of payload bytes in a read_ubuf response frame.
REQ-002 Parameter BUSY_TO, default 15: maximum number of cycles to wait for tx_busy to rise after tx_start.
REQ-003 clk_25  in  1  sole clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset; the design has one clock, and reset is asynchronous and active-low.
REQ-005 link_rx_wr_cmplt  in  1  single-cycle pulse: write-complete acknowledge requested.
REQ-006 get_status  in  1  single-cycle pulse: status response requested.
REQ-007 get_current_nonce  in  1  single-cycle pulse: nonce response requested.
REQ-008 get_signature  in  1  single-cycle pulse: signature response requested.
REQ-009 read_ubuf  in  1  single-cycle pulse: user-buffer dump requested.
REQ-010 host_break  in  1  single-cycle pulse: abort the current frame and flush all pending requests.
REQ-011 status_byte  in  8  live status value.
REQ-012 current_nonce  in  32  live nonce value.
REQ-013 signature  in  32  device signature.
REQ-014 ubuf_rd  out  1  user-buffer read strobe.
REQ-015 ubuf_addr  out  5  user-buffer byte address.
REQ-016 ubuf_data  in  8  user-buffer read data, valid 1 cycle after ubuf_rd.
REQ-017 tx_byte  out  8  byte to the UART transmitter.
REQ-018 tx_start  out  1  1-cycle strobe that launches tx_byte.
REQ-019 tx_busy  in  1  UART transmitter busy.
REQ-020 tx_active  out  1  high whenever the FSM is not in IDLE.
REQ-021 frame_done  out  1  1-cycle pulse after the last byte of a frame completes.
REQ-022 tx_err  out  1  sticky flag: transmitter handshake timeout occurred.

Function
REQ-023 Each request pulse SHALL set its own pending bit; a repeat request while the bit is already set merges into one frame.
REQ-024 Grant priority SHALL be fixed, highest first: ack, status, nonce, signature, ubuf.
REQ-025 Frames SHALL be: ack = 8'h4B; status = 8'h53 + status_byte; nonce = 8'h6E + 4 bytes; signature = 8'h49 + 4 bytes; ubuf = 8'h52 + UBUF_BYTES bytes.
REQ-026 Multi-byte payloads SHALL be sent little-endian.
REQ-027 States SHALL be IDLE, GRANT, LOAD, FETCH, SEND, WAIT_HI, WAIT_LO.
REQ-028 IDLE -> GRANT when any pending bit is set.
REQ-029 GRANT SHALL latch the winning type, snapshot status_byte/current_nonce, clear the winner's pending bit, set byte_cnt=0, then go to LOAD.
REQ-030 LOAD SHALL go to FETCH for ubuf payload bytes (ubuf_rd=1, ubuf_addr=byte_cnt-1); otherwise it SHALL go to SEND.
REQ-031 FETCH SHALL capture ubuf_data, then go to SEND.
REQ-032 SEND SHALL wait for tx_busy=0, then assert tx_start for 1 cycle with tx_byte held, then go to WAIT_HI.
REQ-033 WAIT_HI SHALL go to WAIT_LO on tx_busy=1.
REQ-034 If tx_busy has not risen after BUSY_TO cycles in WAIT_HI, the block SHALL set tx_err, abort the frame without frame_done, and return to IDLE.
REQ-035 WAIT_LO on tx_busy=0: after the last byte, pulse frame_done and go to IDLE; otherwise increment byte_cnt and go to LOAD.
REQ-036 tx_byte SHALL be stable from tx_start until the next LOAD.
REQ-037 A request for the type currently being sent SHALL re-set its pending bit and be served again afterwards.
REQ-038 host_break SHALL clear all pending bits, including requests arriving in the same cycle, and SHALL clear tx_err.
REQ-039 host_break in GRANT, LOAD, FETCH or SEND (before tx_start) SHALL return the FSM to IDLE next cycle with no tx_start.
REQ-040 host_break in WAIT_HI or WAIT_LO SHALL let the current byte finish, then go to IDLE with no frame_done.
REQ-041 From IDLE with tx_busy=0, a request pulse in cycle N SHALL produce the first tx_start in cycle N+4.

Reset
REQ-042 While rst_n=0: FSM=IDLE, pending=0, byte_cnt=0, and tx_start, ubuf_rd, ubuf_addr, tx_byte, tx_active, frame_done and tx_err are all 0.
REQ-043 Reset asserted mid-frame SHALL abort the frame immediately, with no further tx_start.

Verification
REQ-044 get_status pulse with status_byte=8'hA5 and a UART model (busy 10 cycles) -> bytes 53,A5; tx_start first at N+4; one frame_done.
REQ-045 get_signature and link_rx_wr_cmplt in the same cycle, signature=32'h11223344 -> frames 4B, then 49,44,33,22,11.
REQ-046 read_ubuf with RAM[i]=i -> 52,00..1F; ubuf_addr 0..31; 33 tx_start pulses.
REQ-047 host_break during byte 2 of a nonce frame, with get_status pending -> byte 2 completes; no frame_done; nothing further sent.
REQ-048 tx_busy stuck at 0 -> tx_err=1 16 cycles after tx_start, FSM in IDLE; next host_break clears tx_err.
